// File: rtl/timer_irq.sv
`default_nettype none
// ============================================================================
//  Module      : timer_irq
//  Description : Memory-mapped 32-bit reload timer with a level interrupt.
//                TH (reload) at 0x40000000, TL (counter) at 0x40000004,
//                TCON {irq_status, irq_en, enable} at 0x40000008.
//                Optional prescaler (macro TIMER_PRESCALE_EN) adds PSC at
//                0x4000000C; one tick every PSC+1 enabled clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_irq (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout
);

  localparam logic [31:0] c_addr_th   = 32'h4000_0000;
  localparam logic [31:0] c_addr_tl   = 32'h4000_0004;
  localparam logic [31:0] c_addr_tcon = 32'h4000_0008;
  localparam logic [31:0] c_addr_psc  = 32'h4000_000C;
  localparam logic [31:0] c_tl_max    = 32'hFFFF_FFFF;

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic        r_en;
  logic        r_ie;
  logic        r_is;
  logic        r_irq;

  logic        w_sel_th;
  logic        w_sel_tl;
  logic        w_sel_tcon;
  logic        w_sel_psc;
  logic        w_wr_th;
  logic        w_wr_tl;
  logic        w_wr_tcon;
  logic        w_tick;
  logic        w_ovf_tick;
  logic [31:0] w_tl_nxt;
  logic        w_en_nxt;
  logic        w_ie_nxt;
  logic        w_is_nxt;
  logic [31:0] w_psc_rdata;

  // Full 32-bit address decode; anything else is unmapped.
  assign w_sel_th   = (addr == c_addr_th);
  assign w_sel_tl   = (addr == c_addr_tl);
  assign w_sel_tcon = (addr == c_addr_tcon);
  assign w_wr_th    = wr && w_sel_th;
  assign w_wr_tl    = wr && w_sel_tl;
  assign w_wr_tcon  = wr && w_sel_tcon;

`ifdef TIMER_PRESCALE_EN
  logic [15:0] r_psc;
  logic [15:0] r_div;
  logic        w_wr_psc;

  assign w_sel_psc   = (addr == c_addr_psc);
  assign w_wr_psc    = wr && w_sel_psc;
  assign w_tick      = r_en && (r_div == r_psc);
  assign w_psc_rdata = {16'h0, r_psc};

  // Prescaler: PSC register and the enabled-clock divider; a PSC write or
  // disabling the timer restarts the division from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_psc <= 16'h0;
      r_div <= 16'h0;
    end else begin
      if (w_wr_psc) begin
        r_psc <= wdata[15:0];
      end
      if (w_wr_psc || !r_en || (w_wr_tcon && !wdata[0])) begin
        r_div <= 16'h0;
      end else if (w_tick) begin
        r_div <= 16'h0;
      end else begin
        r_div <= r_div + 16'h1;
      end
    end
  end
`else
  assign w_sel_psc   = 1'b0;
  assign w_tick      = r_en;
  assign w_psc_rdata = 32'h0;
`endif

  assign w_ovf_tick = w_tick && (r_tl == c_tl_max);

  // Next-state of counter and control bits; TL writes beat counting, a
  // reload always uses the pre-write TH, and a hardware irq set beats a
  // coinciding software clear so no interrupt is lost.
  always_comb begin
    w_tl_nxt = r_tl;
    w_en_nxt = r_en;
    w_ie_nxt = r_ie;
    w_is_nxt = r_is;
    if (w_wr_tl) begin
      w_tl_nxt = wdata;
    end else if (w_ovf_tick) begin
      w_tl_nxt = r_th;
    end else if (w_tick) begin
      w_tl_nxt = r_tl + 32'h1;
    end
    if (w_wr_tcon) begin
      w_en_nxt = wdata[0];
      w_ie_nxt = wdata[1];
    end
    if (w_ovf_tick && r_ie) begin
      w_is_nxt = 1'b1;
    end else if (w_wr_tcon && !wdata[2]) begin
      w_is_nxt = 1'b0;
    end
  end

  // Register file and the registered interrupt level; irqout follows the
  // control bits exactly, but only ever from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_th  <= 32'h0;
      r_tl  <= 32'h0;
      r_en  <= 1'b0;
      r_ie  <= 1'b0;
      r_is  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_wr_th) begin
        r_th <= wdata;
      end
      r_tl  <= w_tl_nxt;
      r_en  <= w_en_nxt;
      r_ie  <= w_ie_nxt;
      r_is  <= w_is_nxt;
      r_irq <= w_ie_nxt && w_is_nxt;
    end
  end

  // Combinational read mux; zero unless reading a mapped register so the
  // result can be ORed onto the shared CPU read bus.
  always_comb begin
    rdata = 32'h0;
    if (rd) begin
      if (w_sel_th) begin
        rdata = r_th;
      end else if (w_sel_tl) begin
        rdata = r_tl;
      end else if (w_sel_tcon) begin
        rdata = {29'h0, r_is, r_ie, r_en};
      end else if (w_sel_psc) begin
        rdata = w_psc_rdata;
      end
    end
  end

  assign irqout = r_irq;

endmodule
`default_nettype wire

// File: doc/timer_irq.md
TIMER_IRQ -- requirements
Module: timer_irq

Interface
REQ-001 The block SHALL have ports: clk  input  1  CPU clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-003 The block SHALL have port rd  input  1  bus read strobe, the CPU MemRd.
REQ-004 The block SHALL have port wr  input  1  bus write strobe, the CPU MemWr.
REQ-005 The block SHALL have port addr  input  32  byte address, the ALU result.
REQ-006 The block SHALL have port wdata  input  32  write data, register rt.
REQ-007 The block SHALL have port rdata  output  32  read data; it is ORed onto the CPU read bus.
REQ-008 The block SHALL have port irqout  output  1  level interrupt request to Control.

Function
REQ-009 The block SHALL decode the full 32-bit addr: TH (reload) at 0x40000000, TL (counter) at 0x40000004, TCON at 0x40000008.
REQ-010 TCON SHALL be 3 bits: bit0 enable, bit1 irq_en, bit2 irq_status.
REQ-011 rdata SHALL be combinational: it carries the addressed register, with TCON zero-extended, when rd=1 and addr is mapped; otherwise it SHALL be 32'h0.
REQ-012 A write with wr=1 SHALL update the addressed register at the next rising clk edge; unmapped writes SHALL be ignored.
REQ-013 A TCON write SHALL load bits[1:0] from wdata[1:0] and clear bit2 only if wdata[2]=0; software cannot set bit2.
REQ-014 While enable=1, TL SHALL increment by 1 per tick (every clk edge, or per REQ-024).
REQ-015 On a tick with TL=32'hFFFFFFFF, TL SHALL load TH instead of wrapping to 0.
REQ-016 On that same tick, irq_status SHALL be set if irq_en=1.
REQ-017 A TL write SHALL take priority over a coinciding increment or reload.
REQ-018 A hardware set of irq_status SHALL take priority over a coinciding software clear, so no interrupt is lost.
REQ-019 A TH write coinciding with a reload SHALL cause TL to load the old TH value.
REQ-020 irqout SHALL equal irq_en AND irq_status, driven as a registered level with no combinational path from bus inputs.
REQ-021 While enable=0, TL SHALL hold and irq_status SHALL change only through software clear.

Reset
REQ-022 A clk edge with reset=1 SHALL force TH=0, TL=0, TCON=0 and (if built) prescaler state to 0, so irqout=0 on the following cycle.
REQ-023 Reset SHALL override any coinciding write or tick; rdata stays combinational throughout.

Configuration
REQ-024 With macro TIMER_PRESCALE_EN defined, the block SHALL add register PSC (16 bits, zero-extended on read) at 0x4000000C, reset to 0. An internal divider SHALL produce one tick every PSC+1 enabled clocks. Writing PSC or clearing enable SHALL reset the divider to 0.
REQ-025 Without TIMER_PRESCALE_EN, every enabled clk SHALL be a tick, address 0x4000000C SHALL read 0, and writes to it SHALL be ignored.

Verification
REQ-026 Scenario: reset; TH=0xFFFFFFF0, TL=0xFFFFFFFE, TCON=3. Required: TL reads 0xFFFFFFFF after 1 clk and 0xFFFFFFF0 after 2 clk; irq_status=1 and irqout=1 on the following cycle.
REQ-027 Scenario: irqout=1; write TCON=3 (bit2=0). Required: irqout=0 next cycle, counting continues. A write of TCON=7 SHALL NOT set bit2 while clear.
REQ-028 Scenario: TCON=1 (irq_en=0) with TL overflow. Required: TL reloads and irqout stays 0. Separately, a TL=0x1234 write on the overflow cycle reads back 0x1234.
REQ-029 Scenario: TCON software clear on the exact overflow tick with irq_en=1. Required: irq_status=1 afterward.
REQ-030 Scenario: rd=1, addr=0x40000010; also rd=0, addr=0x40000004. Required: rdata=0 in both cases. Then assert reset mid-count with TL=0x55. Required: all registers read 0 next cycle.
REQ-031 Scenario: with TIMER_PRESCALE_EN, PSC=3, TL=0, TCON=1. Required: TL=1 after 4 clk and TL=2 after 8 clk. Without the macro, PSC reads 0.
